// File: rtl/bus_xor_copier_if.sv
// Control bundle shared by the XOR copier, its requester, the bus arbiter and the
// MAR/MDR memory. The tristate sysbus is a separate inout port so that every driver sits on one net.
interface bus_xor_copier_if #(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3
);
  localparam int ADDR_W = WORD_W - OP_W;

  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W-1:0] len;
  logic [WORD_W-1:0] key;
  logic              bus_grant;
  logic              bus_req;
  logic              busy;
  logic              done;
  logic              load_MAR;
  logic              MDR_bus;
  logic              load_MDR;
  logic              CS;
  logic              R_NW;
  logic [2:0]        state_dbg;

  // Handshakes: start is a one-cycle request that is honoured only while busy is low, and
  // src_addr/dst_addr/len/key must be valid in that same cycle. bus_req stays high until
  // the last write of the transfer. bus_grant must stay high from its rising edge until
  // bus_req falls, because the copier does not watch it again once it has been granted.
  modport master (
    input  start, src_addr, dst_addr, len, key, bus_grant,
    output bus_req, busy, done, load_MAR, MDR_bus, load_MDR, CS, R_NW, state_dbg
  );

  modport slave (
    output start, src_addr, dst_addr, len, key, bus_grant,
    input  bus_req, busy, done, load_MAR, MDR_bus, load_MDR, CS, R_NW, state_dbg
  );
endinterface

// File: rtl/bus_xor_copier.sv
// Sysbus master that copies LEN words from SRC to DST, XOR-decoding each word with KEY.
// All control outputs and the bus drive are registered, so they follow the state only.
module bus_xor_copier #(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3
) (
  input  logic              clock,
  input  logic              n_reset,
  bus_xor_copier_if.master  bus,
  inout  wire  [WORD_W-1:0] sysbus
);
  localparam int ADDR_W = WORD_W - OP_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    WR_ADDR = 3'd4,
    WR_DATA = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [WORD_W-1:0] key_q, key_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [WORD_W-1:0] drive_val_q, drive_val_d;
  logic              drive_en_q, drive_en_d;
  logic              bus_req_q, bus_req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load_mar_q, load_mar_d;
  logic              mdr_bus_q, mdr_bus_d;
  logic              load_mdr_q, load_mdr_d;
  logic              cs_q, cs_d;
  logic              r_nw_q, r_nw_d;

  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    count_d   = count_q;
    key_d     = key_q;
    data_d    = data_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          src_ptr_d = bus.src_addr;
          dst_ptr_d = bus.dst_addr;
          count_d   = bus.len;
          key_d     = bus.key;
          state_d   = (bus.len == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        if (bus.bus_grant) state_d = RD_ADDR;
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        data_d  = sysbus ^ key_q;
        state_d = WR_ADDR;
      end
      WR_ADDR: state_d = WR_DATA;
      WR_DATA: begin
        // The pointers wrap modulo the address space, so a range may cross 31 to 0.
        src_ptr_d = src_ptr_q + 1'b1;
        dst_ptr_d = dst_ptr_q + 1'b1;
        count_d   = count_q - 1'b1;
        state_d   = (count_q == ADDR_W'(1)) ? DONE : RD_ADDR;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so each one is valid for the
    // whole cycle of the state it belongs to.
    bus_req_d  = state_d inside {REQ, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA};
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    load_mar_d = state_d inside {RD_ADDR, WR_ADDR};
    mdr_bus_d  = (state_d == RD_DATA);
    load_mdr_d = (state_d == WR_DATA);
    cs_d       = state_d inside {RD_DATA, WR_DATA};
    r_nw_d     = (state_d != WR_DATA);
    drive_en_d = state_d inside {RD_ADDR, WR_ADDR, WR_DATA};

    case (state_d)
      RD_ADDR: drive_val_d = {{OP_W{1'b0}}, src_ptr_d};
      WR_ADDR: drive_val_d = {{OP_W{1'b0}}, dst_ptr_d};
      WR_DATA: drive_val_d = data_d;
      default: drive_val_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      count_q     <= '0;
      key_q       <= '0;
      data_q      <= '0;
      drive_val_q <= '0;
      drive_en_q  <= 1'b0;
      bus_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_mar_q  <= 1'b0;
      mdr_bus_q   <= 1'b0;
      load_mdr_q  <= 1'b0;
      cs_q        <= 1'b0;
      r_nw_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      count_q     <= count_d;
      key_q       <= key_d;
      data_q      <= data_d;
      drive_val_q <= drive_val_d;
      drive_en_q  <= drive_en_d;
      bus_req_q   <= bus_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      load_mar_q  <= load_mar_d;
      mdr_bus_q   <= mdr_bus_d;
      load_mdr_q  <= load_mdr_d;
      cs_q        <= cs_d;
      r_nw_q      <= r_nw_d;
    end
  end

  // drive_en_q is never high in RD_DATA, so the copier cannot fight the memory's MDR.
  assign sysbus = drive_en_q ? drive_val_q : {WORD_W{1'bz}};

  assign bus.bus_req   = bus_req_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.load_MAR  = load_mar_q;
  assign bus.MDR_bus   = mdr_bus_q;
  assign bus.load_MDR  = load_mdr_q;
  assign bus.CS        = cs_q;
  assign bus.R_NW      = r_nw_q;
  assign bus.state_dbg = state_q;
endmodule

// File: doc/bus_xor_copier.md
Name: bus_xor_copier

Overview:
- Bus-master block for the shared sysbus, driving the same MAR/MDR control signals that the ROM and RAM respond to.
- On start, it reads LEN consecutive words from memory at SRC. Each word is XORed with KEY, which decodes data the program encoded with the same XOR code. The result is written to consecutive addresses at DST.
- It sits beside the sequencer and takes the bus only after an external arbiter grants it.

Parameters:
- WORD_W, 8, sysbus/data word width.
- OP_W, 3, opcode field width; address width is ADDR_W = WORD_W-OP_W (5).

Ports:
- clock  in  1  system clock, all state changes on rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
- src_addr  in  ADDR_W  first read address; captured on accepted start.
- dst_addr  in  ADDR_W  first write address; captured on accepted start.
- len  in  ADDR_W  number of words to move (0..31); captured on accepted start.
- key  in  WORD_W  XOR decode key; captured on accepted start.
- bus_grant  in  1  arbiter grant; sampled only in REQ.
- bus_req  out  1  bus request to the arbiter.
- busy  out  1  high from accepted start until DONE completes.
- done  out  1  one-cycle pulse when the transfer is complete.
- load_MAR  out  1  memory latches sysbus[ADDR_W-1:0] into MAR at the clock edge.
- MDR_bus  out  1  memory drives its MDR onto sysbus.
- load_MDR  out  1  memory latches sysbus into MDR or RAM at the clock edge.
- CS  out  1  memory chip select.
- R_NW  out  1  1 = read, 0 = write.
- sysbus  inout  WORD_W  shared tristate bus.

Behaviour:
- Reset (async): state IDLE; all control outputs 0; R_NW=1; busy=0; done=0; bus_req=0; sysbus Z; internal pointers, count and data register 0.
- Reset asserted mid-transfer aborts immediately with the same values. No done is produced.
- IDLE: when start=1, capture src/dst/len/key.
  - len=0: go to DONE without requesting the bus.
  - otherwise: go to REQ.
- REQ: bus_req=1. Stay until bus_grant=1, then go to RD_ADDR. bus_req stays 1 through the last WR_DATA.
- RD_ADDR (1 cycle): drive sysbus = {OP_W'b0, src_ptr}; load_MAR=1. Next state RD_DATA.
- RD_DATA (1 cycle): MDR_bus=1, CS=1, R_NW=1; sysbus not driven by this block. Data register <= sysbus ^ key at the end of the cycle. Next state WR_ADDR.
- WR_ADDR (1 cycle): drive sysbus = {OP_W'b0, dst_ptr}; load_MAR=1. Next state WR_DATA.
- WR_DATA (1 cycle): drive sysbus = data register; load_MDR=1, CS=1, R_NW=0. At the end of the cycle:
  - src_ptr+1 and dst_ptr+1, each modulo 2^ADDR_W (31 wraps to 0);
  - count-1;
  - if count was 1, go to DONE, otherwise go to RD_ADDR.
- DONE (1 cycle): done=1, busy still 1, bus_req=0, sysbus Z. Next state IDLE.
- Each word takes exactly 4 cycles. A transfer takes 4*len cycles from first RD_ADDR to last WR_DATA.
- Bus drive rules:
  - sysbus is driven only in RD_ADDR, WR_ADDR and WR_DATA; it is Z in every other state.
  - MDR_bus is never asserted in a state where this block drives sysbus.
  - Control outputs are decoded from state only (Moore); no glitch paths from inputs.
- Concurrency and grant:
  - start while busy is ignored; no queueing.
  - bus_grant deassertion after REQ is not monitored; the arbiter must hold the grant until bus_req falls.
- Overlapping src/dst ranges are copied word by word in ascending order, with no hazard protection.

Test Plan:
- Memory model: 32 words; the ROM occupies 0..19 and the RAM 20..31.
- Reset → all outputs at reset values, sysbus Z. Pulse n_reset low during RD_DATA of word 2 → outputs return to reset values asynchronously, with no done.
- Basic decode: mem[11..18] = 0x0F,0x08,0x19,0x14,0x0D,0x0D,0x1E,0x0B; src=11, dst=20, len=8, key=0x15; grant 3 cycles after req.
  - Expected: RAM[20..27] = 0x1A,0x1D,0x0C,0x01,0x18,0x18,0x0B,0x1E.
  - Expected: done exactly 32 cycles after the first load_MAR.
- len=0, start=1 → bus_req never rises; done pulses in the cycle after start; busy high for that one cycle.
- Address wrap: src=30, dst=28, len=3, key=0x00, mem[30]=0xA1, mem[31]=0xB2, mem[0]=0xC3.
  - Expected read addresses 30,31,0 and write addresses 28,29,30.
  - Expected RAM[28..30] = 0xA1,0xB2,0xC3.
- Start while busy: a second start with different src mid-transfer → ignored; the first transfer's results are unchanged.
- Bus protocol checker (assertions over all runs):
  - never MDR_bus=1 while this block drives sysbus;
  - load_MAR and load_MDR never both high;
  - sysbus is Z whenever the state is IDLE, REQ, RD_DATA or DONE.
